booth_seq_mult: RTL

Parametrised sequential radix-2 Booth multiplier for signed two's-complement operands. Control FSM and datapath are in one block, with valid/ready handshakes on both the operand and product sides. It replaces the fixed-width, hand-wired Booth control FSM in the multiplier subsystem. An optional early-termination mode finishes early once the remaining multiplier bits need no more add/sub work.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_step.sv | 34 +++
 rtl/booth_seq_mult.sv | 127 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth recoding helper for the sequential multiplier
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_e;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}
    function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational Booth step: add/sub then 1-bit arithmetic shift
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    booth_op_e        op;
    logic [WIDTH:0]   sum;

    // Accumulator update chosen by the recoded bit pair
    always_comb begin
        op = booth_decode(q[0], q_1);
        case (op)
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
    end

    // Arithmetic right shift of {A,Q,q_1}; A's sign bit is replicated
    assign a_next   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next   = {sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-2 Booth multiplier, optional BOOTH_EARLY_TERM_EN
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e                 state;
    logic [WIDTH:0]         a;
    logic [WIDTH:0]         m;
    logic [WIDTH-1:0]       q;
    logic                   q_1;
    logic [CNT_W-1:0]       cnt;

    logic [WIDTH:0]         a_next;
    logic [WIDTH-1:0]       q_next;
    logic                   q_1_next;

    logic                   early_done;
    logic [2*WIDTH-1:0]     early_prod;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a        (a),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .a_next   (a_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;

    // Finish early when the unexamined multiplier bits plus q_1 recode to all NOPs;
    // the remaining steps would only shift, so shift by cnt at once. q[0] is the
    // bit shifted out first, so dropping it folds one shift into the vector.
    always_comb begin
        rem_mask   = ~({WIDTH{1'b1}} << cnt);
        early_done = (((q & rem_mask) == '0) && !q_1) ||
                     (((q & rem_mask) == rem_mask) && q_1);
        early_prod = $signed({a, q[WIDTH-1:1]}) >>> (cnt - CNT_W'(1));
    end
`else
    assign early_done = 1'b0;
    assign early_prod = '0;
`endif

    // Control FSM, operand registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            a         <= '0;
            m         <= '0;
            q         <= '0;
            q_1       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a        <= '0;
                        q        <= multiplier;
                        q_1      <= 1'b0;
                        m        <= {multiplicand[WIDTH-1], multiplicand};
                        cnt      <= CNT_W'(WIDTH);
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    if (early_done) begin
                        product   <= early_prod;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        a   <= a_next;
                        q   <= q_next;
                        q_1 <= q_1_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            product   <= {a_next[WIDTH-1:0], q_next};
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
